nway_cache: RTL

NWAY_CACHE -- requirements
Module: nway_cache

---
 rtl/nway_cache_if.sv | 34 +++
 rtl/nway_cache.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nway_cache_if.sv
// CPU-side and physical-memory-side bus of the set-associative cache.
// master = requester/memory model side, slave = the cache itself.
interface nway_cache_if #(
    parameter int LINE_BYTES = 16
);
    logic                    mem_read;
    logic                    mem_write;
    logic [1:0]              mem_byte_enable;
    logic [15:0]             mem_address;
    logic [15:0]             mem_wdata;
    logic                    mem_resp;
    logic [15:0]             mem_rdata;

    logic                    pmem_read;
    logic                    pmem_write;
    logic [15:0]             pmem_address;
    logic [LINE_BYTES*8-1:0] pmem_wdata;
    logic [LINE_BYTES*8-1:0] pmem_rdata;
    logic                    pmem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/nway_cache.sv
// N-way set-associative write-back cache with tree pseudo-LRU replacement.
// Hits complete combinationally in IDLE; misses go through WRITEBACK/FILL.
module nway_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    nway_cache_if.slave bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = 16 - OFF - IDX;
    localparam int LG     = $clog2(WAYS);
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_e;

    state_e                      state_q;
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][WAYS-1:0]   dirty_q;
    logic [SETS-1:0][WAYS-2:0]   plru_q;
    logic [TAG-1:0]              tag_q  [SETS][WAYS];
    logic [LINE_W-1:0]           data_q [SETS][WAYS];
    logic [LG-1:0]               victim_q;
    logic [IDX-1:0]              idx_q;
    logic [TAG-1:0]              rtag_q;
    logic                        pmem_read_q, pmem_write_q;
    logic [15:0]                 pmem_addr_q;
    logic [15:0]                 hit_cnt_q, miss_cnt_q;
    logic                        retry_q;

    // Tree nodes are heap-ordered (root 0, children 2n+1/2n+2); a node bit
    // points toward the less-recently-used half (0 = lower ways).
    function automatic logic [LG-1:0] plru_victim(input logic [WAYS-2:0] t);
        logic [LG-1:0] n, v;
        logic          d;
        n = '0;
        v = '0;
        for (int l = LG - 1; l >= 0; l--) begin
            d    = t[n];
            v[l] = d;
            n    = LG'(2 * int'(n) + 1 + int'(d));
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [LG-1:0]   w);
        logic [WAYS-2:0] r;
        logic [LG-1:0]   n;
        logic            d;
        r = t;
        n = '0;
        for (int l = LG - 1; l >= 0; l--) begin
            d    = w[l];
            r[n] = ~d;
            n    = LG'(2 * int'(n) + 1 + int'(d));
        end
        return r;
    endfunction

    logic            req, is_wr;
    logic [IDX-1:0]  idx;
    logic [TAG-1:0]  tag;
    logic [OFF-2:0]  woff;
    logic            hit, inv_found;
    logic [LG-1:0]   hit_way, inv_way, victim;
    logic [LINE_W-1:0] hit_line, wr_line;
    logic            retry_match;
    logic            unused_addr0;

    assign req          = bus.mem_read | bus.mem_write;
    assign is_wr        = bus.mem_write;
    assign idx          = bus.mem_address[OFF+IDX-1:OFF];
    assign tag          = bus.mem_address[15:OFF+IDX];
    assign woff         = bus.mem_address[OFF-1:1];
    assign unused_addr0 = bus.mem_address[0];

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = LG'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = LG'(w);
            end
        end
    end

    assign victim   = inv_found ? inv_way : plru_victim(plru_q[idx]);
    assign hit_line = data_q[idx][hit_way];

    always_comb begin
        wr_line = hit_line;
        if (bus.mem_byte_enable[0]) wr_line[{woff, 4'b0000} +: 8] = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) wr_line[{woff, 4'b1000} +: 8] = bus.mem_wdata[15:8];
    end

    // The first hit after a fill is the held request completing, not a new hit.
    assign retry_match = retry_q && (idx == idx_q) && (tag == rtag_q);

    assign bus.mem_resp     = (state_q == IDLE) && req && hit;
    assign bus.mem_rdata    = hit_line[{woff, 4'b0000} +: 16];
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_addr_q;
    assign bus.pmem_wdata   = data_q[idx_q][victim_q];
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            plru_q       <= '0;
            victim_q     <= '0;
            idx_q        <= '0;
            rtag_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            retry_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    retry_q <= 1'b0;
                    if (req && hit) begin
                        plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                        if (is_wr) dirty_q[idx][hit_way] <= 1'b1;
                        if (!retry_match && hit_cnt_q != 16'hFFFF)
                            hit_cnt_q <= hit_cnt_q + 16'd1;
                    end else if (req) begin
                        victim_q <= victim;
                        idx_q    <= idx;
                        rtag_q   <= tag;
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            state_q      <= WRITEBACK;
                            pmem_write_q <= 1'b1;
                            pmem_addr_q  <= {tag_q[idx][victim], idx, {OFF{1'b0}}};
                        end else begin
                            state_q     <= FILL;
                            pmem_read_q <= 1'b1;
                            pmem_addr_q <= {tag, idx, {OFF{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state_q      <= FILL;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                        pmem_addr_q  <= {rtag_q, idx_q, {OFF{1'b0}}};
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state_q                  <= IDLE;
                        pmem_read_q              <= 1'b0;
                        valid_q[idx_q][victim_q] <= 1'b1;
                        dirty_q[idx_q][victim_q] <= 1'b0;
                        retry_q                  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req && hit && is_wr)
            data_q[idx][hit_way] <= wr_line;
        if (state_q == FILL && bus.pmem_resp) begin
            data_q[idx_q][victim_q] <= bus.pmem_rdata;
            tag_q[idx_q][victim_q]  <= rtag_q;
        end
    end
endmodule
